gf_result_serializer: RTL and testbench
=======================================

// Module: gf_result_serializer
// PURPOSE
//  Downstream stage of the carry-less/GF operation core. On the core's op_finish pulse it captures one
//  selected result (out, out_poly, out_mult or out_carry) and streams it LSB-first over a 1-bit
//  valid/ready link with frame marking. It replaces free-running output shift registers with a flow-controlled port.
// PARAMETERS
//  DATA_WIDTH  32  operand width of the core; out_mult is 2*DATA_WIDTH
// PORTS
//  clk        in   1                    single clock; all logic on posedge
//  reset      in   1                    synchronous, active-high reset
//  op_finish  in   1                    one-cycle pulse from core: res_* valid this cycle
//  res_sel    in   2                    0=out 1=out_poly 2=out_mult 3=out_carry; sampled with op_finish
//  in_width   in   $clog2(DATA_WIDTH)+1 active field width, same encoding as core; sampled with op_finish
//  res_out    in   DATA_WIDTH           core normal result
//  res_poly   in   DATA_WIDTH           core reduction result
//  res_mult   in   2*DATA_WIDTH         core multiplication result
//  res_carry  in   1                    core carry out
//  ser_data   out  1                    serial payload bit
//  ser_valid  out  1                    ser_data is valid
//  ser_ready  in   1                    sink accepts; beat transfers when ser_valid && ser_ready
//  ser_last   out  1                    marks the final beat of a frame
//  busy       out  1                    frame in progress (state != IDLE)
//  overrun    out  1                    sticky: a result was dropped; cleared only by reset
// BEHAVIOUR
//  - Reset: ser_data=0, ser_valid=0, ser_last=0, busy=0, overrun=0, state=IDLE, counters 0.
//    Reset during a frame aborts it; no partial bits after the reset cycle.
//  - FSM: IDLE -> SHIFT on op_finish; SHIFT -> IDLE after the last payload handshake
//    (-> PARITY instead when GF_SER_PARITY_EN is defined); PARITY -> IDLE on its handshake.
//  - Capture at the op_finish edge into a 2*DATA_WIDTH shift register. Frame length L:
//    sel 0/1: W bits; sel 2: 2*W bits; sel 3: 1 bit. W = in_width, clamped to DATA_WIDTH
//    when in_width is 0 or > DATA_WIDTH.
//  - Latency: op_finish at cycle N -> ser_valid=1 with bit 0 at N+1.
//    With ready held high, one bit per cycle. ser_last is high with bit L-1 (or the parity beat).
//  - Backpressure: while ser_valid && !ser_ready, ser_data and ser_last stay stable.
//  - op_finish while busy, not on the final handshake: result dropped, overrun<=1, frame unaffected.
//  - op_finish in the same cycle as the final handshake: new result captured, state stays SHIFT,
//    bit 0 of the new frame at the next cycle (no bubble), overrun unchanged.
//  - op_finish in IDLE the cycle after a frame ends: accepted normally.
//  - ser_valid=0 and ser_data=0 in IDLE.
// CONFIGURATION
//  - GF_SER_PARITY_EN defined: one extra beat after the payload. Value = XOR of all L payload bits
//    (even parity). ser_last moves to the parity beat; frame length is L+1.
//  - GF_SER_PARITY_EN undefined: no PARITY state or parity logic; frame length is L.
// STRUCTURE
//  - Package gf_ser_pkg: state enum (IDLE, SHIFT, PARITY); res_sel encodings
//    (SEL_OUT, SEL_POLY, SEL_MULT, SEL_CARRY); function for the clamped-width/length calculation.
//  - Sub-module gf_piso: parameterised parallel-load shift register with load, shift-enable and
//    down-counter, asserting last at count==1. The top holds the FSM, select mux, overrun and parity.
// TESTING
//  1. DW=32, sel=0, in_width=8, res_out=0xA5, ready=1 -> bits 1,0,1,0,0,1,0,1 at N+1..N+8;
//     last at N+8; busy low at N+9.
//  2. sel=2, in_width=4, res_mult=0x3C, ready low 3 cycles after beat 2 -> 8 beats 0,0,1,1,1,1,0,0;
//     beat 2 held stable for 3 cycles.
//  3. op_finish mid-frame (beat 3 of 8) -> overrun=1 and stays 1; current frame completes unchanged.
//  4. op_finish coincident with the final handshake -> new frame bit 0 the next cycle, overrun=0.
//  5. reset asserted at beat 5 -> next cycle all outputs 0, state IDLE; next op_finish starts cleanly.
//  6. Edge cases: in_width=0, sel=1 -> 32 beats; sel=3, res_carry=1 -> one beat, data=1, last=1.
//     With GF_SER_PARITY_EN, 0xA5/W=8 -> 9th beat 0 with last.

Source files
------------

// File: rtl/gf_ser_pkg.sv
// Shared types and helpers for the GF result serializer.
// Optional parity beat selected by GF_SER_PARITY_EN.
package gf_ser_pkg;

`ifdef GF_SER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_e;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
    } ser_state_e;
`endif

    localparam logic [1:0] SEL_OUT   = 2'd0;
    localparam logic [1:0] SEL_POLY  = 2'd1;
    localparam logic [1:0] SEL_MULT  = 2'd2;
    localparam logic [1:0] SEL_CARRY = 2'd3;

    // Width 0 or anything above the core width means "full width".
    function automatic int unsigned frame_len(input logic [1:0] sel,
                                              input int unsigned width,
                                              input int unsigned dw);
        int unsigned w;
        w = ((width == 32'd0) || (width > dw)) ? dw : width;
        case (sel)
            SEL_MULT:  return 32'd2 * w;
            SEL_CARRY: return 32'd1;
            default:   return w;
        endcase
    endfunction

endpackage

// File: rtl/gf_result_serializer_if.sv
// 1-bit valid/ready serial link with frame-end marking.
interface gf_result_serializer_if;
    logic ser_data;
    logic ser_valid;
    logic ser_ready;
    logic ser_last;

    modport master (output ser_data, output ser_valid, output ser_last, input ser_ready);
    modport slave  (input ser_data, input ser_valid, input ser_last, output ser_ready);
endinterface

// File: rtl/gf_piso.sv
// Parallel-load, LSB-first shift register with a beat down-counter and
// a registered last flag that is high while count == 1.
module gf_piso #(
    parameter int WIDTH = 64,
    parameter int CW    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CW-1:0]    load_len,
    output logic             data,
    output logic             last
);

    logic [WIDTH-1:0] sr_r;
    logic [CW-1:0]    cnt_r;
    logic             last_r;

    // Load has priority so a new frame can start on the old frame's final shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_r   <= '0;
            cnt_r  <= '0;
            last_r <= 1'b0;
        end else if (load) begin
            sr_r   <= load_data;
            cnt_r  <= load_len;
            last_r <= (load_len == CW'(1));
        end else if (shift_en && (cnt_r != '0)) begin
            sr_r   <= sr_r >> 1;
            cnt_r  <= cnt_r - CW'(1);
            last_r <= (cnt_r == CW'(2));
        end else begin
            sr_r   <= sr_r;
            cnt_r  <= cnt_r;
            last_r <= last_r;
        end
    end

    assign data = sr_r[0];
    assign last = last_r;

endmodule

// File: rtl/gf_result_serializer.sv
// Captures one GF core result on op_finish and streams it LSB-first.
// Define GF_SER_PARITY_EN to append an even-parity beat to each frame.
module gf_result_serializer
    import gf_ser_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        op_finish,
    input  logic [1:0]                  res_sel,
    input  logic [$clog2(DATA_WIDTH):0] in_width,
    input  logic [DATA_WIDTH-1:0]       res_out,
    input  logic [DATA_WIDTH-1:0]       res_poly,
    input  logic [2*DATA_WIDTH-1:0]     res_mult,
    input  logic                        res_carry,
    gf_result_serializer_if.master      ser,
    output logic                        busy,
    output logic                        overrun
);

    localparam int SW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(SW) + 1;

    ser_state_e    state_r, next_state_s;
    logic [SW-1:0] cap_raw_s, cap_masked_s;
    logic [CW-1:0] len_s;
    logic          load_s, shift_s, hs_s, final_hs_s;
    logic          piso_data_s, piso_last_s;
    logic          overrun_r;

    // Bits above the frame length are zeroed so the register drains to 0.
    function automatic logic [SW-1:0] len_mask(input int unsigned len);
        logic [SW-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < SW; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

    // Result select and frame length, sampled only when a load happens.
    always_comb begin
        cap_raw_s = '0;
        case (res_sel)
            SEL_OUT:   cap_raw_s = {{DATA_WIDTH{1'b0}}, res_out};
            SEL_POLY:  cap_raw_s = {{DATA_WIDTH{1'b0}}, res_poly};
            SEL_MULT:  cap_raw_s = res_mult;
            SEL_CARRY: cap_raw_s = {{(SW-1){1'b0}}, res_carry};
            default:   cap_raw_s = '0;
        endcase
        len_s        = CW'(frame_len(res_sel, 32'(in_width), 32'(DATA_WIDTH)));
        cap_masked_s = cap_raw_s & len_mask(32'(len_s));
    end

    assign hs_s = ser.ser_valid && ser.ser_ready;

`ifdef GF_SER_PARITY_EN
    logic parity_r;

    function automatic logic even_parity(input logic [SW-1:0] v);
        return ^v;
    endfunction

    assign final_hs_s = (state_r == PARITY) && hs_s;

    // Parity of the captured frame is fixed at load time.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_r <= 1'b0;
        end else if (load_s) begin
            parity_r <= even_parity(cap_masked_s);
        end else begin
            parity_r <= parity_r;
        end
    end
`else
    assign final_hs_s = (state_r == SHIFT) && hs_s && piso_last_s;
`endif

    // Next state, load and shift control.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (op_finish) begin
                    next_state_s = SHIFT;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                shift_s = hs_s;
                if (hs_s && piso_last_s) begin
`ifdef GF_SER_PARITY_EN
                    next_state_s = PARITY;
`else
                    next_state_s = op_finish ? SHIFT : IDLE;
                    load_s       = op_finish;
`endif
                end else begin
                    next_state_s = SHIFT;
                end
            end
`ifdef GF_SER_PARITY_EN
            PARITY: begin
                if (hs_s) begin
                    next_state_s = op_finish ? SHIFT : IDLE;
                    load_s       = op_finish;
                end else begin
                    next_state_s = PARITY;
                end
            end
`endif
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // A result arriving while a frame is still running, other than on its final beat, is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (op_finish && (state_r != IDLE) && !final_hs_s) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    gf_piso #(.WIDTH(SW), .CW(CW)) u_piso (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .shift_en  (shift_s),
        .load_data (cap_masked_s),
        .load_len  (len_s),
        .data      (piso_data_s),
        .last      (piso_last_s)
    );

    // Output mux from registered state.
    always_comb begin
        ser.ser_data = 1'b0;
        ser.ser_last = 1'b0;
        case (state_r)
            SHIFT: begin
                ser.ser_data = piso_data_s;
`ifdef GF_SER_PARITY_EN
                ser.ser_last = 1'b0;
`else
                ser.ser_last = piso_last_s;
`endif
            end
`ifdef GF_SER_PARITY_EN
            PARITY: begin
                ser.ser_data = parity_r;
                ser.ser_last = 1'b1;
            end
`endif
            default: begin
                ser.ser_data = 1'b0;
                ser.ser_last = 1'b0;
            end
        endcase
    end

    assign ser.ser_valid = (state_r != IDLE);
    assign busy          = (state_r != IDLE);
    assign overrun       = overrun_r;

endmodule

// File: tb/tb_gf_result_serializer.sv
// Directed bench for gf_result_serializer; expected frames built from hand-chosen vectors.
module tb_gf_result_serializer;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_finish;
    logic [1:0]    res_sel;
    logic [5:0]    in_width;
    logic [DW-1:0] res_out, res_poly;
    logic [2*DW-1:0] res_mult;
    logic          res_carry;
    logic          busy, overrun;

    int n_checks = 0;
    int n_pass   = 0;

    gf_result_serializer_if ser_if();

    gf_result_serializer #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_finish (op_finish),
        .res_sel   (res_sel),
        .in_width  (in_width),
        .res_out   (res_out),
        .res_poly  (res_poly),
        .res_mult  (res_mult),
        .res_carry (res_carry),
        .ser       (ser_if),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] sel, input logic [5:0] w, input logic [DW-1:0] o,
                         input logic [DW-1:0] p, input logic [2*DW-1:0] m, input logic c);
        res_sel = sel; in_width = w; res_out = o; res_poly = p; res_mult = m; res_carry = c;
        op_finish = 1'b1;
        tick();
        op_finish = 1'b0;
    endtask

    task automatic build(input logic [63:0] v, input int len, output logic [64:0] bits, output int flen);
        bits = '0;
        for (int i = 0; i < len; i++) bits[i] = v[i];
        flen = len;
`ifdef GF_SER_PARITY_EN
        bits[len] = ^bits;
        flen = len + 1;
`endif
    endtask

    task automatic recv(input string tag, input logic [64:0] bits, input int flen,
                        input int hold_at, input int drop_at, input bit chain);
        for (int i = 0; i < flen; i++) begin
            check($sformatf("%s_valid%0d", tag, i), 64'(ser_if.ser_valid), 64'd1);
            check($sformatf("%s_data%0d", tag, i), 64'(ser_if.ser_data), 64'(bits[i]));
            check($sformatf("%s_last%0d", tag, i), 64'(ser_if.ser_last), 64'(i == flen - 1));
            if (i == hold_at) begin
                ser_if.ser_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check($sformatf("%s_hold_valid%0d", tag, k), 64'(ser_if.ser_valid), 64'd1);
                    check($sformatf("%s_hold_data%0d", tag, k), 64'(ser_if.ser_data), 64'(bits[i]));
                    check($sformatf("%s_hold_last%0d", tag, k), 64'(ser_if.ser_last), 64'(i == flen - 1));
                end
                ser_if.ser_ready = 1'b1;
            end
            if ((i == drop_at) || (chain && (i == flen - 1))) op_finish = 1'b1;
            tick();
            op_finish = 1'b0;
        end
        if (!chain) begin
            check({tag, "_end_busy"}, 64'(busy), 64'd0);
            check({tag, "_end_valid"}, 64'(ser_if.ser_valid), 64'd0);
            check({tag, "_end_data"}, 64'(ser_if.ser_data), 64'd0);
        end
    endtask

    initial begin
        logic [64:0] bits;
        int          flen;

        reset = 1'b1; op_finish = 1'b0; ser_if.ser_ready = 1'b1;
        res_sel = 2'd0; in_width = 6'd0; res_out = '0; res_poly = '0; res_mult = '0; res_carry = 1'b0;
        tick(); tick();
        check("rst_valid", 64'(ser_if.ser_valid), 64'd0);
        check("rst_data", 64'(ser_if.ser_data), 64'd0);
        check("rst_last", 64'(ser_if.ser_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        reset = 1'b0;
        tick();

        // 0xA5, 8 bits: 1,0,1,0,0,1,0,1
        start(2'd0, 6'd8, 32'h0000_00A5, 32'h0, 64'h0, 1'b0);
        build(64'h00A5, 8, bits, flen);
        recv("t1", bits, flen, -1, -1, 1'b0);

        // 0x3C as 2*4 bits with backpressure on beat 2
        start(2'd2, 6'd4, 32'h0, 32'h0, 64'h3C, 1'b0);
        build(64'h003C, 8, bits, flen);
        recv("t2", bits, flen, 2, -1, 1'b0);

        // Back-to-back: new op on the final handshake, 0x6 as 4 bits
        start(2'd0, 6'd8, 32'h0000_00A5, 32'h0, 64'h0, 1'b0);
        res_out = 32'h0000_0006; in_width = 6'd4;
        build(64'h00A5, 8, bits, flen);
        recv("t4a", bits, flen, -1, -1, 1'b1);
        check("t4_overrun", 64'(overrun), 64'd0);
        check("t4_busy", 64'(busy), 64'd1);
        build(64'h0006, 4, bits, flen);
        recv("t4b", bits, flen, -1, -1, 1'b0);
        check("t4_overrun_end", 64'(overrun), 64'd0);

        // Drop mid-frame at beat 3
        start(2'd0, 6'd8, 32'h0000_00A5, 32'h0, 64'h0, 1'b0);
        res_out = 32'h0000_00FF;
        build(64'h00A5, 8, bits, flen);
        recv("t3", bits, flen, -1, 3, 1'b0);
        check("t3_overrun", 64'(overrun), 64'd1);
        tick();
        check("t3_overrun_sticky", 64'(overrun), 64'd1);

        // Reset at beat 5
        start(2'd0, 6'd8, 32'h0000_00A5, 32'h0, 64'h0, 1'b0);
        build(64'h00A5, 8, bits, flen);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5_data%0d", i), 64'(ser_if.ser_data), 64'(bits[i]));
            tick();
        end
        check("t5_data5", 64'(ser_if.ser_data), 64'(bits[5]));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_valid", 64'(ser_if.ser_valid), 64'd0);
        check("t5_data", 64'(ser_if.ser_data), 64'd0);
        check("t5_last", 64'(ser_if.ser_last), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_overrun", 64'(overrun), 64'd0);
        tick();
        check("t5_idle_valid", 64'(ser_if.ser_valid), 64'd0);
        start(2'd0, 6'd8, 32'h0000_003C, 32'h0, 64'h0, 1'b0);
        build(64'h003C, 8, bits, flen);
        recv("t5r", bits, flen, -1, -1, 1'b0);

        // in_width=0 clamps to 32
        start(2'd1, 6'd0, 32'h0, 32'hDEAD_BEEF, 64'h0, 1'b0);
        build(64'hDEAD_BEEF, 32, bits, flen);
        recv("t6w0", bits, flen, -1, -1, 1'b0);

        // in_width above 32 clamps to 32
        start(2'd0, 6'd40, 32'h1234_5678, 32'h0, 64'h0, 1'b0);
        build(64'h1234_5678, 32, bits, flen);
        recv("t6w40", bits, flen, -1, -1, 1'b0);

        // Carry: single beat
        start(2'd3, 6'd8, 32'hFFFF_FFFF, 32'h0, 64'h0, 1'b1);
        build(64'h1, 1, bits, flen);
        recv("t6c", bits, flen, -1, -1, 1'b0);

        check("final_overrun", 64'(overrun), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
